// File: rtl/stack_unit.sv
// stack_unit: LIFO data stack with registered pop data, full/empty status and sticky overflow/underflow flags.
module stack_unit #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic [WIDTH-1:0]  tos,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   ONE_C    = 1;
  localparam logic [ADDR_W-1:0] ONE_A    = 1;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  dout_q;
  logic              dv_q, ovf_q, unf_q;
  logic [ADDR_W-1:0] top_idx, wr_idx;
  logic              replace, push_ok, pop_ok, ovf_set, unf_set, wr_en;
  always_comb begin
    full    = count_q == FULL_CNT;
    empty   = count_q == '0;
    top_idx = count_q[ADDR_W-1:0] - ONE_A;
    tos     = empty ? '0 : mem_q[top_idx];
    // push+pop on a non-empty stack overwrites the top in place
    replace = push & pop & ~empty;
    push_ok = push & ~replace & ~full;
    pop_ok  = pop & ~push & ~empty;
    ovf_set = push & ~pop & full;
    unf_set = pop & empty;
    wr_en   = push_ok | replace;
    wr_idx  = replace ? top_idx : count_q[ADDR_W-1:0];
    count_d = push_ok ? count_q + ONE_C : pop_ok ? count_q - ONE_C : count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dv_q    <= replace | pop_ok;
      if (replace | pop_ok) dout_q <= tos;
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      unf_q   <= unf_set | (unf_q & ~clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din;
  end
  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- LIFO data stack that services the push/pop commands issued by the stack-machine controller. It is the responder side of the controller's push/pop interface.
- Holds DEPTH words and tracks a stack pointer.
- Returns popped data through a registered output with a one-cycle valid strobe.
- Reports full/empty status and sticky overflow/underflow errors, and exposes the current top-of-stack for operand fetch.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer/address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- push  input  1  push request, sampled on rising clk.
- pop  input  1  pop request, sampled on rising clk.
- din  input  WIDTH  data to push.
- clr_err  input  1  clears the sticky error flags.
- dout  output  WIDTH  registered data of the last accepted pop.
- dout_valid  output  1  one-cycle pulse: dout updated by an accepted pop.
- tos  output  WIDTH  current top entry; 0 when empty.
- count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set by a push rejected while full.
- underflow  output  1  sticky; set by a pop rejected while empty.

Behaviour:
- Reset (async, immediate): count=0, dout=0, dout_valid=0, overflow=0, underflow=0, tos=0, empty=1, full=0. Memory contents are don't-care; tos must not expose stale memory.
- Storage: DEPTH x WIDTH register array. The pointer sp equals count. Push writes mem[sp] and sets sp=sp+1. Pop reads mem[sp-1] and sets sp=sp-1. Both use ADDR_W-bit indexing.
- full, empty and tos are combinational from count and memory. tos = mem[count-1] when count>0, else 0.
- Per rising edge, priority as listed:
  - push=1, pop=1, count>0 (replace): dout<=old top; dout_valid<=1; mem[count-1]<=din; count unchanged. Same-cycle tos shows the old top; the next cycle shows din.
  - push=1, pop=1, count==0: pop is rejected and sets underflow. Push is accepted: mem[0]<=din, count<=1. dout_valid<=0.
  - push only, count<DEPTH: mem[count]<=din; count<=count+1.
  - push only, count==DEPTH: no write; count unchanged; overflow<=1.
  - pop only, count>0: dout<=mem[count-1]; dout_valid<=1; count<=count-1.
  - pop only, count==0: dout holds; dout_valid<=0; underflow<=1.
  - Neither request: dout holds; dout_valid<=0.
- Latency:
  - Pop data appears on dout in the cycle after the sampling edge and is held until the next accepted pop.
  - A pushed value is visible on tos in the cycle after the sampling edge.
- Errors:
  - overflow and underflow stay set until clr_err=1 at an edge, which clears both.
  - If clr_err and a new error occur in the same cycle, the new error wins (flag stays 1).
- Requests are single-cycle. Holding push or pop high for N cycles issues N operations. The controller must not assert push and pop with the intent of two separate operations.
- No wrap-around: count saturates at 0 and DEPTH via rejection. Rejected operations never modify memory.
- Reset asserted mid-sequence discards all contents and errors. The first edge after deassertion behaves as from empty.

Test Plan:
- Push 0x11, 0x22, 0x33 on consecutive cycles, then three pops. Required: tos=0x33 before the pops; dout sequence 0x33, 0x22, 0x11, each with a one-cycle dout_valid; empty=1 and count=0 at the end.
- Fill with DEPTH=16 pushes of values 0..15, then push 0xAA. Required: full=1; count=16; overflow=1; tos stays 0x0F. Pop then returns 0x0F.
- Pop from empty after reset. Required: underflow=1; dout_valid=0; dout=0; count=0. clr_err one cycle later clears it. clr_err together with another empty pop leaves underflow=1.
- With stack [0x05, 0x07] (top 0x07), assert push+pop with din=0x09. Required: dout=0x07 with dout_valid; count stays 2; tos=0x09 the next cycle.
- Assert push+pop on an empty stack with din=0x3C. Required: count=1; tos=0x3C; underflow=1; dout_valid=0.
- Push 0x44, then assert rst asynchronously between edges. Required: count=0, empty=1, tos=0 and all flags 0 immediately, without waiting for a clock edge. A following push 0x55 gives tos=0x55.
